// File: rtl/arbiter_rr_stream.sv
// N-way round-robin stream arbiter: packet-locked grant, one registered output beat.
// o_ready follows i_ready combinationally; data only reaches o_data through the output register.
module arbiter_rr_stream #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int SW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [N-1:0]  i_valid,
  input  logic [DW-1:0] i_data [N],
  input  logic [N-1:0]  i_last,
  output logic [N-1:0]  o_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic [SW-1:0] o_src,
  input  logic          i_ready
);
  logic          valid_q, last_q, lock_q;
  logic [DW-1:0] data_q;
  logic [SW-1:0] src_q, ptr_q, owner_q;

  logic          load_en, sel_en, xfer;
  logic [SW-1:0] sel;
  logic [SW:0]   cand;

  assign load_en = !valid_q || i_ready;

  // Scan starts one past the last winner; the extra index bit keeps the wrap exact for any N.
  always_comb begin
    sel    = owner_q;
    sel_en = lock_q;
    cand   = '0;
    if (!lock_q) begin
      for (int i = 1; i <= N; i++) begin
        cand = {1'b0, ptr_q} + (SW+1)'(i);
        if (cand >= (SW+1)'(N)) cand = cand - (SW+1)'(N);
        if (!sel_en && i_valid[cand[SW-1:0]]) begin
          sel_en = 1'b1;
          sel    = cand[SW-1:0];
        end
      end
    end
  end

  // A locked owner keeps its ready even while idle, so packet bubbles never let others in.
  always_comb begin
    o_ready = '0;
    if (sel_en && load_en && !i_reset) o_ready[sel] = 1'b1;
  end

  assign xfer = sel_en && i_valid[sel] && load_en && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= '0;
      ptr_q   <= SW'(N-1);
      owner_q <= '0;
      lock_q  <= 1'b0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= i_data[sel];
      last_q  <= i_last[sel];
      src_q   <= sel;
      ptr_q   <= sel;
      owner_q <= sel;
      lock_q  <= !i_last[sel];
    end else if (load_en) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_src   = src_q;

  // Producer contract: an offered beat stays put until taken.
  generate
    for (genvar k = 0; k < N; k++) begin : g_chk
      a_hold: assert property (@(posedge i_clk) disable iff (i_reset)
        (i_valid[k] && !o_ready[k]) |=> (i_valid[k] && $stable(i_data[k]) && $stable(i_last[k])));
    end
  endgenerate

  a_out_stable: assert property (@(posedge i_clk) disable iff (i_reset)
    (valid_q && !i_ready) |=> ($stable(data_q) && $stable(last_q) && $stable(src_q)));

endmodule
